// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch-side inputs and the decode/PC-side outputs of fetch_queue.
//   PCResult       [31:0]  current PC from the program counter register
//   Instruction    [31:0]  instruction memory read data for PCResult
//   Flush                  taken branch/jump resolved in decode
//   ID_Stall               decode hazard stall; head entry must not be consumed
//   PC_Write               PC load enable (combinational)
//   ID_Valid               head entry valid
//   ID_Instruction [31:0]  head instruction, 0 when empty
//   ID_PCPlus4     [31:0]  head PC+4, 0 when empty
//   Count          [CW-1:0] occupancy, 0..DEPTH
// master: the queue itself.  slave: the surrounding datapath / testbench.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic [31:0]   PCResult;
   logic [31:0]   Instruction;
   logic          Flush;
   logic          ID_Stall;
   logic          PC_Write;
   logic          ID_Valid;
   logic [31:0]   ID_Instruction;
   logic [31:0]   ID_PCPlus4;
   logic [CW-1:0] Count;

   modport master (
      input  PCResult, Instruction, Flush, ID_Stall,
      output PC_Write, ID_Valid, ID_Instruction, ID_PCPlus4, Count
   );

   modport slave (
      output PCResult, Instruction, Flush, ID_Stall,
      input  PC_Write, ID_Valid, ID_Instruction, ID_PCPlus4, Count
   );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular-buffer instruction fetch queue between the PC / instruction memory
// and decode. Each accepted cycle captures {Instruction, PCResult+4}; entries
// are shown to decode in order (show-ahead). PC_Write advances the PC whenever
// an entry is accepted, and also on Flush so the PC loads the redirect target.
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high; clears pointers, count and storage
//   bus    fetch_queue_if.master (see interface header for signal list)
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          Clk,
   input  logic          Reset,
   fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc4_q   [DEPTH];
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;

   logic          valid;
   logic          pop;
   logic          push;
   logic [31:0]   pc_plus4;

   assign valid    = (count_q != '0);
   assign pop      = valid & ~bus.ID_Stall & ~bus.Flush;
   // When full, a slot is only available if the head leaves this same cycle.
   assign push     = ~Reset & ~bus.Flush & ((count_q < CW'(DEPTH)) | pop);
   assign pc_plus4 = bus.PCResult + 32'd4;

   assign bus.PC_Write       = push | (bus.Flush & ~Reset);
   assign bus.ID_Valid       = valid;
   assign bus.ID_Instruction = valid ? instr_q[rd_q] : '0;
   assign bus.ID_PCPlus4     = valid ? pc4_q[rd_q]   : '0;
   assign bus.Count          = count_q;

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (bus.Flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (pop)  rd_d = rd_q + AW'(1);
         if (push) wr_d = wr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc4_q[i]   <= '0;
         end
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (push) begin
            instr_q[wr_q] <= bus.Instruction;
            pc4_q[wr_q]   <= pc_plus4;
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Table of per-cycle inputs with hand-derived PC_Write and Count, plus a
// queue-based scoreboard that predicts ID_Valid / ID_Instruction / ID_PCPlus4.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int NV    = 25;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();
   fetch_queue #(.DEPTH(DEPTH)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   typedef struct {
      logic        rst, flush, stall;
      logic [31:0] pc, instr;
      logic        exp_pcw;
      int          exp_count;
   } vec_t;

   typedef struct {
      logic [31:0] instr, pc4;
   } ent_t;

   vec_t vecs [NV];
   ent_t sb [$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic r, input logic f, input logic s,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic pcw, input int cnt);
      vecs[i] = '{rst: r, flush: f, stall: s, pc: pc, instr: ins, exp_pcw: pcw, exp_count: cnt};
   endtask

   initial begin
      // Plain stream, no stall: steady Count=1
      setv(0,  0,0,0, 32'h0,        32'hA0, 1, 0);
      setv(1,  0,0,0, 32'h4,        32'hA1, 1, 1);
      setv(2,  0,0,0, 32'h8,        32'hA2, 1, 1);
      setv(3,  0,1,0, 32'hC,        32'hA3, 1, 1);
      // Stall from empty until full
      setv(4,  0,0,1, 32'h100,      32'hB0, 1, 0);
      setv(5,  0,0,1, 32'h104,      32'hB1, 1, 1);
      setv(6,  0,0,1, 32'h108,      32'hB2, 1, 2);
      setv(7,  0,0,1, 32'h10C,      32'hB3, 1, 3);
      setv(8,  0,0,1, 32'h110,      32'hB4, 0, 4);
      // Full: one-cycle release pops and pushes across the pointer wrap
      setv(9,  0,0,0, 32'h110,      32'hB4, 1, 4);
      setv(10, 0,0,1, 32'h114,      32'hB5, 0, 4);
      setv(11, 0,0,0, 32'h114,      32'hB5, 1, 4);
      setv(12, 0,0,0, 32'h118,      32'hB6, 1, 4);
      setv(13, 0,1,0, 32'h11C,      32'hB7, 1, 4);
      // Count=3 then Flush together with stall
      setv(14, 0,0,1, 32'h200,      32'hC0, 1, 0);
      setv(15, 0,0,1, 32'h204,      32'hC1, 1, 1);
      setv(16, 0,0,1, 32'h208,      32'hC2, 1, 2);
      setv(17, 0,1,1, 32'h20C,      32'hC3, 1, 3);
      setv(18, 0,0,0, 32'h300,      32'hD0, 1, 0);
      setv(19, 0,0,0, 32'h304,      32'hD1, 1, 1);
      // PC+4 wrap
      setv(20, 0,0,0, 32'hFFFFFFFC, 32'hE0, 1, 1);
      setv(21, 0,0,1, 32'h0,        32'hE1, 1, 1);
      // Reset with Count=2, then resume
      setv(22, 1,0,1, 32'h4,        32'hE2, 0, 2);
      setv(23, 0,0,0, 32'h8,        32'hE3, 1, 0);
      setv(24, 0,0,0, 32'hC,        32'hE4, 1, 1);

      Reset = 1'b1;
      bus.PCResult = '0; bus.Instruction = '0; bus.Flush = 1'b0; bus.ID_Stall = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      check("rst_pcw",   32'(bus.PC_Write),  32'd0);
      check("rst_count", 32'(bus.Count),     32'd0);
      check("rst_valid", 32'(bus.ID_Valid),  32'd0);
      check("rst_instr", bus.ID_Instruction, 32'd0);
      check("rst_pc4",   bus.ID_PCPlus4,     32'd0);
      @(posedge Clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         logic m_pop, m_push;
         logic [31:0] e_instr, e_pc4;
         Reset            = vecs[i].rst;
         bus.Flush        = vecs[i].flush;
         bus.ID_Stall     = vecs[i].stall;
         bus.PCResult     = vecs[i].pc;
         bus.Instruction  = vecs[i].instr;
         @(negedge Clk);
         check($sformatf("v%0d_pcw", i),   32'(bus.PC_Write), 32'(vecs[i].exp_pcw));
         check($sformatf("v%0d_count", i), 32'(bus.Count),    32'(vecs[i].exp_count));
         e_instr = (sb.size() != 0) ? sb[0].instr : 32'd0;
         e_pc4   = (sb.size() != 0) ? sb[0].pc4   : 32'd0;
         check($sformatf("v%0d_valid", i), 32'(bus.ID_Valid), 32'(sb.size() != 0));
         check($sformatf("v%0d_instr", i), bus.ID_Instruction, e_instr);
         check($sformatf("v%0d_pc4", i),   bus.ID_PCPlus4,     e_pc4);
         // Scoreboard: entries queued when the stimulus is accepted, retired when decode takes them
         m_pop  = (sb.size() != 0) && !vecs[i].stall && !vecs[i].flush;
         m_push = !vecs[i].rst && !vecs[i].flush && ((sb.size() < DEPTH) || m_pop);
         @(posedge Clk);
         if (vecs[i].rst || vecs[i].flush) begin
            sb.delete();
         end else begin
            if (m_pop)  void'(sb.pop_front());
            if (m_push) sb.push_back('{instr: vecs[i].instr, pc4: vecs[i].pc + 32'd4});
         end
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
